// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode types: entry layout and the canonical NOP.
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetcher -> queue -> decode handshake bundle.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int bits  = XLEN,
    parameter int DEPTH = 4
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic            in_valid;
    logic [bits-1:0] in_instr;
    logic [bits-1:0] in_pc;
    logic            in_ready;
    logic            out_valid;
    logic [bits-1:0] out_instr;
    logic [bits-1:0] out_pc;
    logic            out_ready;
    logic            flush;
    logic [CW-1:0]   count;

    modport master (
        output in_valid, in_instr, in_pc,
        output out_ready, flush,
        input  in_ready, out_valid,
        input  out_instr, out_pc, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc,
        input  out_ready, flush,
        output in_ready, out_valid,
        output out_instr, out_pc, count
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular instruction buffer between fetcher and decode.
// Wrap-bit pointers; flush drops everything, no fall-through.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int bits  = XLEN,
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    fetch_queue_if.slave q
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [bits-1:0] last_pc_q, last_pc_d;

    logic [AW-1:0]   wr_idx, rd_idx;
    logic            empty, full;
    logic            push, pop;

    assign wr_idx = wr_q[AW-1:0];
    assign rd_idx = rd_q[AW-1:0];

    assign empty = (wr_q == rd_q);
    assign full  = (wr_idx == rd_idx) && (wr_q[AW] != rd_q[AW]);

    assign push = q.in_valid && !full;
    assign pop  = q.out_ready && !empty;

    assign q.in_ready  = !full;
    assign q.out_valid = !empty;
    assign q.count     = wr_q - rd_q;
    assign q.out_instr = empty ? NOP_INSTR : mem_q[rd_idx].instr;
    assign q.out_pc    = empty ? last_pc_q : mem_q[rd_idx].pc;

    always_comb begin
        wr_d      = wr_q;
        rd_d      = rd_q;
        last_pc_d = last_pc_q;
        if (q.flush) begin
            rd_d = wr_q;
        end else begin
            if (push) begin
                wr_d = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d      = rd_q + 1'b1;
                last_pc_d = mem_q[rd_idx].pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= '0;
            rd_q      <= '0;
            last_pc_q <= '0;
        end else begin
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            last_pc_q <= last_pc_d;
        end
    end

    // Storage needs no reset: empty state masks it on the outputs.
    always_ff @(posedge clk) begin
        if (!rst && !q.flush && push) begin
            mem_q[wr_idx] <= '{pc: q.in_pc, instr: q.in_instr};
        end
    end

`ifndef SYNTHESIS
    a_no_push_full: assert property (
        @(posedge clk) disable iff (rst) !(push && full));
    a_count_max: assert property (
        @(posedge clk) disable iff (rst) int'(q.count) <= DEPTH);
    a_depth_pow2: assert property (
        @(posedge clk) (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));
    a_width: assert property (
        @(posedge clk) bits == XLEN);
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with hand-computed expectations.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.bits(32), .DEPTH(4)) bus ();

    fetch_queue #(.bits(32), .DEPTH(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .q   (bus.slave)
    );

    task automatic check_eq(input string tag,
                            input logic [63:0] got,
                            input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic push1(input logic [31:0] pc, input logic [31:0] ins);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = ins;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_reset();
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_count", 64'(bus.count), 64'd0);
        check_eq("rst_out_instr", 64'(bus.out_instr), 64'h13);
        check_eq("rst_out_pc", 64'(bus.out_pc), 64'd0);
    endtask

    initial begin
        idle();
        bus.in_pc    = '0;
        bus.in_instr = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        expect_reset();

        // single push then pop
        push1(32'h0, 32'h1fc18197);
        check_eq("sp_valid", 64'(bus.out_valid), 64'd1);
        check_eq("sp_pc", 64'(bus.out_pc), 64'h0);
        check_eq("sp_instr", 64'(bus.out_instr), 64'h1fc18197);
        check_eq("sp_count", 64'(bus.count), 64'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("sp_count0", 64'(bus.count), 64'd0);
        check_eq("sp_valid0", 64'(bus.out_valid), 64'd0);
        check_eq("sp_nop", 64'(bus.out_instr), 64'h13);

        // fill and back-pressure
        for (int i = 0; i < 4; i++) push1(32'(4 * i), 32'h100 + 32'(i));
        check_eq("fill_count", 64'(bus.count), 64'd4);
        check_eq("fill_ready", 64'(bus.in_ready), 64'd0);
        check_eq("fill_head", 64'(bus.out_pc), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'd16;
        bus.in_instr = 32'h104;
        step();
        check_eq("full_drop", 64'(bus.count), 64'd4);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_eq("pop_ready", 64'(bus.in_ready), 64'd1);
        check_eq("pop_count", 64'(bus.count), 64'd3);
        step();
        bus.in_valid = 1'b0;
        check_eq("refill", 64'(bus.count), 64'd4);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_eq("drain_pc", 64'(bus.out_pc), 64'(4 * k));
            check_eq("drain_ins", 64'(bus.out_instr), 64'(32'h100 + 32'(k)));
            step();
        end
        bus.out_ready = 1'b0;
        check_eq("drain_empty", 64'(bus.out_valid), 64'd0);
        check_eq("last_pc", 64'(bus.out_pc), 64'd16);

        // streaming with pointer wrap
        for (int i = 0; i <= 12; i++) begin
            if (i < 12) begin
                bus.in_valid = 1'b1;
                bus.in_pc    = 32'(4 * i);
                bus.in_instr = 32'hA000 + 32'(i);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (i > 0) begin
                check_eq("st_valid", 64'(bus.out_valid), 64'd1);
                check_eq("st_pc", 64'(bus.out_pc), 64'(4 * (i - 1)));
                check_eq("st_ins", 64'(bus.out_instr), 64'(32'hA000 + 32'(i - 1)));
                check_eq("st_count", 64'(bus.count), 64'd1);
            end
            bus.out_ready = 1'b1;
            step();
        end
        idle();
        check_eq("st_end", 64'(bus.count), 64'd0);

        // flush mid-stream
        push1(32'h10, 32'h1);
        push1(32'h14, 32'h2);
        push1(32'h18, 32'h3);
        check_eq("fl_pre", 64'(bus.count), 64'd3);
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h100;
        bus.in_instr  = 32'h4;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        step();
        idle();
        check_eq("fl_count", 64'(bus.count), 64'd0);
        check_eq("fl_valid", 64'(bus.out_valid), 64'd0);
        check_eq("fl_ready", 64'(bus.in_ready), 64'd1);
        check_eq("fl_lastpc", 64'(bus.out_pc), 64'h2c);
        push1(32'h200, 32'h5);
        check_eq("fl_head", 64'(bus.out_pc), 64'h200);
        check_eq("fl_cnt1", 64'(bus.count), 64'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // reset mid-operation
        push1(32'h300, 32'h6);
        push1(32'h304, 32'h7);
        check_eq("rm_pre", 64'(bus.count), 64'd2);
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h308;
        bus.in_instr = 32'h8;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        expect_reset();
        for (int i = 0; i < 3; i++) push1(32'h400 + 32'(4 * i), 32'h90 + 32'(i));
        check_eq("rm_count", 64'(bus.count), 64'd3);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rm_pc", 64'(bus.out_pc), 64'(32'h400 + 32'(4 * i)));
            check_eq("rm_ins", 64'(bus.out_instr), 64'(32'h90 + 32'(i)));
            step();
        end
        bus.out_ready = 1'b0;
        check_eq("rm_empty", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
